// File: rtl/race_draw_ctrl.sv
// race_draw_ctrl
// Pixel-plot controller for a top-down racing screen. A start pulse paints
// the left grass border, the road, the right grass border and then the car,
// one pixel per cycle, row-major within each region. Afterwards the block
// waits for frame ticks; a single left/right request erases the car
// rectangle, moves it by STEP pixels (clamped to the road) and redraws it.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   start               : full redraw request (accepted in IDLE / WAIT_MOVE)
//   frame_tick          : per-frame strobe; steering is sampled only on it
//   move_left/right     : steering requests; exactly one must be set to move
//   straight            : explicit "no lateral move" request
//   plot, x, y, colour  : combinational pixel write port
//   busy                : high while drawing or updating the car position
//   car_x               : registered left column of the car
module race_draw_ctrl #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int GRASS_W  = 30,
    parameter int CAR_W    = 5,
    parameter int CAR_H    = 12,
    parameter int CAR_Y    = 100,
    parameter int STEP     = 4,
    parameter int COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] GRASS_COLOR = 3'b010,
    parameter logic [COLOR_W-1:0] ROAD_COLOR  = 3'b000,
    parameter logic [COLOR_W-1:0] CAR_COLOR   = 3'b100,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               straight,
    output logic               plot,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [COLOR_W-1:0] colour,
    output logic               busy,
    output logic [XW-1:0]      car_x
);

    typedef enum logic [2:0] {
        IDLE, BG_LEFT, BG_ROAD, BG_RIGHT, DRAW_CAR, WAIT_MOVE, ERASE_CAR, UPDATE_POS
    } state_t;

    localparam int ROAD_W    = SCREEN_W - 2 * GRASS_W;
    localparam int CENTER_X  = (SCREEN_W - CAR_W) / 2;
    localparam int RIGHT_MAX = SCREEN_W - GRASS_W - CAR_W;

    // One extra bit so that car_x - STEP stays a small negative number
    // instead of wrapping to a large column.
    localparam logic signed [XW:0] STEP_S  = (XW+1)'(STEP);
    localparam logic signed [XW:0] LMIN_S  = (XW+1)'(GRASS_W);
    localparam logic signed [XW:0] RMAX_S  = (XW+1)'(RIGHT_MAX);

    state_t          state, state_next;
    logic [XW-1:0]   cx;
    logic [YW-1:0]   cy;
    logic [XW-1:0]   pending;
    logic [XW-1:0]   cur_w;
    logic [YW-1:0]   cur_h;
    logic            drawing;
    logic            col_last;
    logic            last_px;
    logic            move_req;
    logic signed [XW:0] wide_x, left_raw, left_t, right_raw, right_t, target_w;

    // Region size of the current draw state
    always_comb begin
        cur_w   = '0;
        cur_h   = '0;
        drawing = 1'b0;
        case (state)
            BG_LEFT, BG_RIGHT: begin
                cur_w   = XW'(GRASS_W);
                cur_h   = YW'(SCREEN_H);
                drawing = 1'b1;
            end
            BG_ROAD: begin
                cur_w   = XW'(ROAD_W);
                cur_h   = YW'(SCREEN_H);
                drawing = 1'b1;
            end
            DRAW_CAR, ERASE_CAR: begin
                cur_w   = XW'(CAR_W);
                cur_h   = YW'(CAR_H);
                drawing = 1'b1;
            end
            default: ;
        endcase
    end

    assign col_last = (cx == cur_w - XW'(1));
    assign last_px  = drawing && col_last && (cy == cur_h - YW'(1));

    // Clamped steering target
    always_comb begin
        wide_x    = signed'({1'b0, car_x});
        left_raw  = wide_x - STEP_S;
        left_t    = (left_raw < LMIN_S) ? LMIN_S : left_raw;
        right_raw = wide_x + STEP_S;
        right_t   = (right_raw > RMAX_S) ? RMAX_S : right_raw;
        target_w  = move_left ? left_t : right_t;
    end

    assign move_req = frame_tick && (move_left ^ move_right) && !straight;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = BG_LEFT;
            BG_LEFT:    if (last_px) state_next = BG_ROAD;
            BG_ROAD:    if (last_px) state_next = BG_RIGHT;
            BG_RIGHT:   if (last_px) state_next = DRAW_CAR;
            DRAW_CAR:   if (last_px) state_next = WAIT_MOVE;
            WAIT_MOVE: begin
                if (start)
                    state_next = BG_LEFT;
                else if (move_req && (target_w != wide_x))
                    state_next = ERASE_CAR;
            end
            ERASE_CAR:  if (last_px) state_next = UPDATE_POS;
            UPDATE_POS: state_next = DRAW_CAR;
            default:    state_next = IDLE;
        endcase
    end

    // State register and region scan counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cx <= '0;
                cy <= '0;
            end else if (drawing) begin
                if (col_last) begin
                    cx <= '0;
                    cy <= cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end
        end
    end

    // Car position; the new column is held in pending until the old
    // rectangle has been erased.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            car_x   <= XW'(CENTER_X);
            pending <= '0;
        end else begin
            if ((state == IDLE || state == WAIT_MOVE) && start)
                car_x <= XW'(CENTER_X);
            else if (state == UPDATE_POS)
                car_x <= pending;
            if (state == WAIT_MOVE && state_next == ERASE_CAR)
                pending <= target_w[XW-1:0];
        end
    end

    // Pixel port
    always_comb begin
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        busy   = !(state == IDLE || state == WAIT_MOVE);
        case (state)
            BG_LEFT: begin
                plot   = 1'b1;
                x      = cx;
                y      = cy;
                colour = GRASS_COLOR;
            end
            BG_ROAD: begin
                plot   = 1'b1;
                x      = XW'(GRASS_W) + cx;
                y      = cy;
                colour = ROAD_COLOR;
            end
            BG_RIGHT: begin
                plot   = 1'b1;
                x      = XW'(SCREEN_W - GRASS_W) + cx;
                y      = cy;
                colour = GRASS_COLOR;
            end
            DRAW_CAR: begin
                plot   = 1'b1;
                x      = car_x + cx;
                y      = YW'(CAR_Y) + cy;
                colour = CAR_COLOR;
            end
            ERASE_CAR: begin
                plot   = 1'b1;
                x      = car_x + cx;
                y      = YW'(CAR_Y) + cy;
                colour = ROAD_COLOR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_race_draw_ctrl.sv
// Bench for race_draw_ctrl: directed scenarios plus random steering, all
// checked against a pixel-list model of the screen and a clamped car column.
module tb_race_draw_ctrl;

    localparam int SW = 160, SH = 120, GW = 30, CW = 5, CH = 12, CY = 100, STP = 4;
    localparam int GREEN = 2, BLACK = 0, CARC = 4;
    localparam int LMIN = GW, RMAX = SW - GW - CW, CENTER = (SW - CW) / 2;

    logic       clock, reset, start, frame_tick, move_left, move_right, straight;
    logic       plot, busy;
    logic [7:0] x, car_x;
    logic [6:0] y;
    logic [2:0] colour;

    int vectors = 0;
    int miscompares = 0;
    int m_car;
    logic [19:0] exp_q[$];

    race_draw_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right), .straight(straight),
        .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy), .car_x(car_x)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] pix(input int b, input int p, input int xx, input int yy, input int c);
        return {1'(b), 1'(p), 8'(xx), 7'(yy), 3'(c)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic add_rect(input int left, input int c);
        for (int r = 0; r < CH; r++)
            for (int k = 0; k < CW; k++)
                exp_q.push_back(pix(1, 1, left + k, CY + r, c));
    endtask

    task automatic build_frame(input int car);
        exp_q.delete();
        for (int r = 0; r < SH; r++)
            for (int k = 0; k < GW; k++) exp_q.push_back(pix(1, 1, k, r, GREEN));
        for (int r = 0; r < SH; r++)
            for (int k = GW; k < SW - GW; k++) exp_q.push_back(pix(1, 1, k, r, BLACK));
        for (int r = 0; r < SH; r++)
            for (int k = SW - GW; k < SW; k++) exp_q.push_back(pix(1, 1, k, r, GREEN));
        add_rect(car, CARC);
    endtask

    task automatic build_move(input int old_x, input int new_x);
        exp_q.delete();
        add_rect(old_x, BLACK);
        exp_q.push_back(pix(1, 0, 0, 0, 0));
        add_rect(new_x, CARC);
    endtask

    // Called on a falling edge; leaves the inputs idle one cycle later.
    task automatic pulse(input logic s, input logic ml, input logic mr, input logic st, input logic ft);
        start = s; move_left = ml; move_right = mr; straight = st; frame_tick = ft;
        @(negedge clock);
        start = 0; move_left = 0; move_right = 0; straight = 0; frame_tick = 0;
    endtask

    // Compares every cycle of exp_q; at index glitch, start/steering are
    // pulsed and must have no effect.
    task automatic run_seq(input string tag, input int glitch);
        int nbad = 0;
        int first = -1;
        logic [19:0] obs, first_obs, first_exp;
        first_obs = '0;
        first_exp = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clock);
            obs = {busy, plot, x, y, colour};
            if (obs !== exp_q[i]) begin
                if (first < 0) begin
                    first = i; first_obs = obs; first_exp = exp_q[i];
                end
                nbad++;
            end
            if (i == glitch) begin
                start = 1; frame_tick = 1; move_left = 1;
            end else begin
                start = 0; frame_tick = 0; move_left = 0;
            end
        end
        vectors++;
        assert (nbad === 0) else begin
            miscompares++;
            $error("FAIL %s: %0d bad cycles, first at %0d observed %h expected %h",
                   tag, nbad, first, first_obs, first_exp);
        end
        @(negedge clock);
        start = 0; frame_tick = 0; move_left = 0;
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_plot_end"}, 32'(plot), 0);
        chk({tag, "_car_x"}, 32'(car_x), 32'(m_car));
    endtask

    task automatic do_frame(input string tag);
        m_car = CENTER;
        build_frame(m_car);
        pulse(1, 0, 0, 0, 0);
        run_seq(tag, -1);
    endtask

    task automatic do_move(input string tag, input logic ml, input logic mr, input logic st,
                           input logic ft, input int glitch);
        int tgt;
        bit go;
        go  = ft && (ml != mr) && !st;
        tgt = ml ? ((m_car - STP < LMIN) ? LMIN : m_car - STP)
                 : ((m_car + STP > RMAX) ? RMAX : m_car + STP);
        if (go && tgt != m_car) begin
            build_move(m_car, tgt);
            m_car = tgt;
            pulse(0, ml, mr, st, ft);
            run_seq(tag, glitch);
        end else begin
            int active = 0;
            pulse(0, ml, mr, st, ft);
            for (int i = 0; i < 3; i++) begin
                if (plot !== 1'b0 || busy !== 1'b0) active++;
                @(negedge clock);
            end
            chk({tag, "_noplot"}, 32'(active), 0);
            chk({tag, "_car_x"}, 32'(car_x), 32'(m_car));
        end
    endtask

    initial begin
        clock = 0; reset = 1; start = 0; frame_tick = 0;
        move_left = 0; move_right = 0; straight = 0;
        repeat (2) @(negedge clock);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_colour", 32'(colour), 0);
        chk("rst_car_x", 32'(car_x), CENTER);
        reset = 0;

        // Steering in IDLE is ignored; nothing happens without start
        pulse(0, 1, 0, 0, 1);
        repeat (3) @(negedge clock);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_plot", 32'(plot), 0);

        do_frame("frame0");
        do_move("left77", 1, 0, 0, 1, -1);
        chk("left77_pos", 32'(m_car), 73);
        do_move("right73", 0, 1, 0, 1, -1);
        do_move("both", 1, 1, 0, 1, -1);
        do_move("no_tick", 0, 1, 0, 0, -1);
        do_move("straight", 1, 0, 1, 1, -1);
        do_move("erase_start", 1, 0, 0, 1, 10);

        for (int i = 0; i < 30 && m_car > LMIN; i++) do_move("to_left", 1, 0, 0, 1, -1);
        chk("left_limit", 32'(car_x), LMIN);
        do_move("left_hold", 1, 0, 0, 1, -1);

        do_frame("refresh30");

        for (int i = 0; i < 30 && m_car < RMAX; i++) do_move("to_right", 0, 1, 0, 1, -1);
        chk("right_limit", 32'(car_x), RMAX);
        do_move("right_hold", 0, 1, 0, 1, -1);

        for (int i = 0; i < 25; i++) begin
            logic ml, mr, st, ft;
            ml = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            ft = ($urandom_range(0, 3) != 0);
            do_move("rand", ml, mr, st, ft, -1);
        end

        // Reset in the middle of the road fill
        pulse(1, 0, 0, 0, 0);
        repeat (GW * SH + 50) @(negedge clock);
        chk("mid_road_plot", 32'(plot), 1);
        chk("mid_road_x", 32'(x), GW + 50);
        #2 reset = 1;
        #1;
        chk("mid_rst_plot", 32'(plot), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_x", 32'(x), 0);
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        chk("mid_rst_idle", 32'(busy), 0);
        do_frame("frame_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/race_draw_ctrl.md
RACE_DRAW_CTRL -- requirements
Module: race_draw_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter GRASS_W, default 30, width of each grass border; road spans x = GRASS_W .. SCREEN_W-GRASS_W-1.
REQ-004 SHALL have parameters CAR_W (default 5), CAR_H (default 12) and CAR_Y (default 100): car size and fixed top row.
REQ-005 SHALL have parameter STEP, default 4, lateral pixels per move.
REQ-006 SHALL have parameters COLOR_W (default 3), GRASS_COLOR (default 3'b010), ROAD_COLOR (default 3'b000) and CAR_COLOR (default 3'b100).
REQ-007 SHALL have parameters XW (default 8) and YW (default 7), the coordinate widths.
REQ-008 clock  input  1  sole clock; all state changes on the rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 start  input  1  start pulse: draws the full screen from IDLE or WAIT_MOVE.
REQ-011 frame_tick  input  1  one-cycle pulse per frame; moves are sampled only on it.
REQ-012 move_left, move_right, straight  input  1 each  steering requests.
REQ-013 plot  output  1  pixel write enable.
REQ-014 x  output  XW  pixel column.
REQ-015 y  output  YW  pixel row.
REQ-016 colour  output  COLOR_W  pixel colour.
REQ-017 busy  output  1  high in every state except IDLE and WAIT_MOVE.
REQ-018 car_x  output  XW  registered left column of the car.

Function
REQ-019 States SHALL be: IDLE, BG_LEFT, BG_ROAD, BG_RIGHT, DRAW_CAR, WAIT_MOVE, ERASE_CAR, UPDATE_POS.
REQ-020 Internal counters cx and cy SHALL scan each region row-major: cx increments each cycle; at region width-1 cx wraps to 0 and cy increments.
REQ-021 Both counters SHALL clear to 0 on every state change.
REQ-022 plot, x, y and colour SHALL be combinational from the state and counters; plot=1 only in BG_LEFT, BG_ROAD, BG_RIGHT, DRAW_CAR and ERASE_CAR.
REQ-023 Outside those states, x, y and colour SHALL be 0.
REQ-024 BG_LEFT: x=cx, y=cy, GRASS_COLOR, region GRASS_W x SCREEN_H.
REQ-025 BG_ROAD: x=GRASS_W+cx, ROAD_COLOR, region (SCREEN_W-2*GRASS_W) x SCREEN_H.
REQ-026 BG_RIGHT: x=SCREEN_W-GRASS_W+cx, GRASS_COLOR, region GRASS_W x SCREEN_H.
REQ-027 DRAW_CAR: x=car_x+cx, y=CAR_Y+cy, CAR_COLOR, region CAR_W x CAR_H.
REQ-028 ERASE_CAR: same pixels as DRAW_CAR, drawn in ROAD_COLOR; only the car rectangle is erased.
REQ-029 Each draw state SHALL last exactly width*height cycles and advance on its last pixel.
REQ-030 Draw-state order SHALL be BG_LEFT -> BG_ROAD -> BG_RIGHT -> DRAW_CAR -> WAIT_MOVE.
REQ-031 After ERASE_CAR the state SHALL go to UPDATE_POS, which lasts 1 cycle, loads the new car_x and then goes to DRAW_CAR.
REQ-032 IDLE: start=1 SHALL go to BG_LEFT and load car_x = (SCREEN_W-CAR_W)/2, using integer division.
REQ-033 WAIT_MOVE: start=1 SHALL take priority and behave as in REQ-032 (full redraw, car recentred).
REQ-034 WAIT_MOVE with frame_tick=1: exactly one of move_left or move_right asserted SHALL compute a target position.
REQ-035 Left target = max(car_x-STEP, GRASS_W).
REQ-036 Right target = min(car_x+STEP, SCREEN_W-GRASS_W-CAR_W).
REQ-037 If the target differs from car_x, the state SHALL go to ERASE_CAR with the target held in a pending register; if it does not, the state SHALL stay in WAIT_MOVE.
REQ-038 straight, both moves asserted, no move, or frame_tick=0 SHALL leave the state in WAIT_MOVE.
REQ-039 start, move and frame_tick inputs SHALL be ignored while busy=1.
REQ-040 Target arithmetic SHALL use XW+1 bits so that car_x-STEP cannot wrap below zero.

Reset
REQ-041 reset=1 SHALL immediately force IDLE, cx=cy=0, car_x=(SCREEN_W-CAR_W)/2, pending=0, and plot, x, y, colour and busy to 0, including mid-draw.
REQ-042 After reset release, the block SHALL stay in IDLE until start=1.

Verification (defaults)
REQ-043 Reset release, 1-cycle start pulse -> busy=1 from next cycle; plot high 19260 consecutive cycles (3600 green x0-29, 12000 black x30-129, 3600 green x130-159, 60 car x77-81 y100-111); then busy=0 and car_x=77.
REQ-044 In WAIT_MOVE with car_x=77, move_left with frame_tick -> 60 ROAD_COLOR plots x77-81, 1 idle cycle, 60 CAR_COLOR plots x73-77; car_x=73.
REQ-045 car_x=33, move_left -> car_x=30; a further move_left -> no plot, stays WAIT_MOVE; car_x=123 with move_right -> 125, then holds at 125.
REQ-046 move_left=move_right=1 with frame_tick, or move_right without frame_tick -> no plot, car_x unchanged.
REQ-047 Reset asserted mid-BG_ROAD -> same cycle plot=0, busy=0; re-start redraws from x=0,y=0.
REQ-048 start during ERASE_CAR is ignored; start in WAIT_MOVE with car_x=30 -> full 19260-cycle redraw, car_x=77.
